// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one unsigned magnitude comparator
// among NREQ requesters and returns a registered, index-tagged gt/eq/lt result.
module cmp_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_gt,
    output logic              rsp_eq,
    output logic              rsp_lt
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_RSP} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_gt_q, rsp_gt_d;
    logic            rsp_eq_q, rsp_eq_d;
    logic            rsp_lt_q, rsp_lt_d;

    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            any_req;

    assign any_req = |req;

    // First set request at or after ptr, wrapping through the index width.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ptr_q + IDW'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_CMP;
            S_CMP:   state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = '0;
        busy_d      = (state_d != S_IDLE);
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_gt_d    = rsp_gt_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_lt_d    = rsp_lt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d[win] = 1'b1;
                    op_a_d     = a_in[win*W +: W];
                    op_b_d     = b_in[win*W +: W];
                    id_d       = win;
                end
            end
            S_CMP: begin
                rsp_gt_d    = (op_a_q >  op_b_q);
                rsp_eq_d    = (op_a_q == op_b_q);
                rsp_lt_d    = (op_a_q <  op_b_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                ptr_d       = id_q + IDW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_gt_q    <= rsp_gt_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_lt_q    <= rsp_lt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = rsp_gt_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_lt    = rsp_lt_q;

endmodule
